wordle_guess_eval: RTL and testbench
====================================

# wordle_guess_eval

Sequential Wordle scoring engine. It accepts a five-letter guess and the secret target word, and grades every letter as green (right letter, right place), yellow (right letter, wrong place) or gray (not in the word). Duplicate letters are handled by the standard consume-once rule. It also tracks the attempt count and win/lose status. It sits upstream of the VGA 640x480 renderer, which draws the tile colours from `result` and the board row from `attempt`.

## Interface
Parameters:
- `MAX_GUESSES`, default 6: number of guesses before `game_over` asserts.

Ports:
- `clk`  in  1  master clock (50 MHz).
- `clr`  in  1  reset, asynchronous, active-high.
- `new_game`  in  1  synchronous clear of attempt, win and game_over. Sampled only in IDLE.
- `start`  in  1  request to score `guess` against `target`. Sampled only in IDLE.
- `guess`  in  25  letter i at [5i+4:5i]. Letter 0 is leftmost. Codes 0..25 are A..Z; codes 26..31 are blank.
- `target`  in  25  secret word, same encoding as `guess`.
- `busy`  out  1  high from GREEN through DONE.
- `done`  out  1  one-cycle pulse when `result` is valid.
- `result`  out  10  colour of letter i at [2i+1:2i]. 00 = gray, 01 = yellow, 10 = green. 11 is never produced.
- `attempt`  out  3  number of completed guesses, 0..MAX_GUESSES.
- `win`  out  1  sticky; set when a scored guess is all green.
- `game_over`  out  1  sticky; high when `win` is set or `attempt == MAX_GUESSES`.

## Operation
- The FSM has four states: IDLE, GREEN, YELLOW, DONE.
- IDLE:
  - If `start` is high and `game_over` is low, latch `guess` and `target` and go to GREEN.
  - If `start` is high and `game_over` is high, ignore it.
  - If `new_game` is high, clear `attempt`, `win` and `game_over`.
  - If `new_game` and `start` are high in the same cycle, `new_game` wins and `start` is ignored.
- GREEN (1 cycle):
  - Compare all 5 positions in parallel.
  - Where g[i] == t[i] and the code is ≤ 25, set result[i] = 10 and used[i] = 1.
  - All other letters: result[i] = 00, used[i] = 0.
- YELLOW (5 cycles, index i = 0..4, one letter per cycle):
  - If result[i] is 10, skip it.
  - Otherwise find the lowest j with used[j] == 0 and t[j] == g[i] (code ≤ 25).
  - If such a j exists, set result[i] = 01 and used[j] = 1. If not, the letter stays 00.
- DONE (1 cycle):
  - Assert `done`.
  - Increment `attempt` (saturating at MAX_GUESSES).
  - Set `win` if result == 10'b10_10_10_10_10.
  - Return to IDLE.
- `result` holds its value until the next GREEN entry. It is cleared to 0 in GREEN before the new grading is written.
- `start` and input changes while busy are ignored, because the operands are latched.
- Blank codes (26..31) never match anything, not even each other.

## Timing
- Reset values: state = IDLE, `busy` = 0, `done` = 0, `result` = 0, `attempt` = 0, `win` = 0, `game_over` = 0. Internal latches and `used` are also 0.
- Latency: if `start` is sampled at edge k, then GREEN is cycle k+1, YELLOW is k+2..k+6, and `done` is high for cycle k+7 only. Back-to-back guesses have a minimum spacing of 8 cycles.
- `attempt`, `win` and `game_over` update on the edge that ends DONE, so they are visible from cycle k+8.
- `clr` asserted mid-operation returns the block to reset values immediately. No `done` pulse is emitted for the aborted guess.

## Structure
- Shared package `wordle_pkg`:
  - letter width (5) and word length (5)
  - colour codes GRAY, YELLOW, GREEN
  - the `BLANK_MIN` = 26 constant
  - the FSM state encoding
- The same package is reused by the renderer.
- Sub-module `wordle_first_match`: combinational priority finder. Inputs are one guess letter, the target word and the `used` mask. Outputs are a found flag and a one-hot j.

## Test plan
- guess CRANE, target CRANE → `done` at k+7, result = 10_10_10_10_10, `win` = 1, `game_over` = 1, `attempt` = 1.
- guess SPEED, target ABIDE → result {L4..L0} = 01_00_01_00_00 (only the first E is yellow, D is yellow), `win` = 0.
- guess EERIE, target THERE → result = 10_00_01_00_01 (E4 green, E0 yellow, E1 gray, R yellow).
- Six wrong guesses → `attempt` = 6 and `game_over` = 1 after the 6th `done`. A further `start` produces no `busy`. `new_game` then clears `attempt` to 0.
- `start` pulsed again at k+3 with a different guess → ignored, and the result matches the first guess. A guess containing code 31 against a target containing code 31 → that letter is 00.
- `clr` asserted during YELLOW at k+4 → all outputs 0 in the same cycle, no `done` pulse. A fresh `start` then scores correctly.

Source files
------------

// File: rtl/wordle_pkg.sv
// Shared Wordle types and constants: letter/word geometry, tile colours and
// the scoring FSM encoding. Also used by the VGA renderer.
package wordle_pkg;

    localparam int LETTER_W = 5;
    localparam int WORD_LEN = 5;
    localparam int WORD_W   = LETTER_W * WORD_LEN;
    localparam int RESULT_W = 2 * WORD_LEN;

    typedef logic [1:0] colour_t;
    localparam colour_t GRAY   = 2'b00;
    localparam colour_t YELLOW = 2'b01;
    localparam colour_t GREEN  = 2'b10;

    // Codes 26..31 are blanks and must never match, not even each other.
    localparam logic [LETTER_W-1:0] BLANK_MIN = 5'd26;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GREEN,
        ST_YELLOW,
        ST_DONE
    } state_t;

    function automatic logic is_letter(input logic [LETTER_W-1:0] code);
        return code < BLANK_MIN;
    endfunction

endpackage

// File: rtl/wordle_first_match.sv
// Combinational priority finder: lowest unused target position holding the
// given guess letter, returned as a found flag plus a one-hot position.
module wordle_first_match
    import wordle_pkg::*;
(
    input  logic [LETTER_W-1:0] letter,
    input  logic [WORD_W-1:0]   target,
    input  logic [WORD_LEN-1:0] used,
    output logic                found,
    output logic [WORD_LEN-1:0] onehot
);

    logic [WORD_LEN-1:0] cand;

    generate
        for (genvar gi = 0; gi < WORD_LEN; gi++) begin : g_cand
            assign cand[gi] = !used[gi] && is_letter(letter)
                              && (target[gi*LETTER_W +: LETTER_W] == letter);
        end
    endgenerate

    assign found  = |cand;
    // Two's-complement trick isolates the lowest set bit, i.e. the lowest j.
    assign onehot = cand & (~cand + 1'b1);

endmodule

// File: rtl/wordle_guess_eval.sv
// Sequential Wordle scoring engine: one green pass, five single-letter yellow
// passes with consume-once duplicate handling, then attempt/win bookkeeping.
module wordle_guess_eval
    import wordle_pkg::*;
#(
    parameter int MAX_GUESSES = 6
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                new_game,
    input  logic                start,
    input  logic [WORD_W-1:0]   guess,
    input  logic [WORD_W-1:0]   target,
    output logic                busy,
    output logic                done,
    output logic [RESULT_W-1:0] result,
    output logic [2:0]          attempt,
    output logic                win,
    output logic                game_over
);

    localparam logic [2:0] ATTEMPT_MAX = 3'(MAX_GUESSES);
    localparam logic [2:0] LAST_IDX    = 3'(WORD_LEN - 1);

    state_t               state_reg, state_next;
    logic [WORD_W-1:0]    guess_reg, target_reg;
    colour_t              result_reg [WORD_LEN];
    logic [WORD_LEN-1:0]  used_reg;
    logic [2:0]           idx_reg;
    logic [2:0]           attempt_reg;
    logic                 win_reg;

    logic [LETTER_W-1:0]  guess_letter [WORD_LEN];
    logic [WORD_LEN-1:0]  green_hit;
    logic [RESULT_W-1:0]  result_packed;
    logic                 fm_found;
    logic [WORD_LEN-1:0]  fm_onehot;

    generate
        for (genvar gi = 0; gi < WORD_LEN; gi++) begin : g_lane
            assign guess_letter[gi] = guess_reg[gi*LETTER_W +: LETTER_W];
            assign green_hit[gi]    = is_letter(guess_letter[gi])
                                      && (guess_letter[gi] == target_reg[gi*LETTER_W +: LETTER_W]);
            assign result_packed[2*gi +: 2] = result_reg[gi];
        end
    endgenerate

    wordle_first_match u_first_match (
        .letter (guess_letter[idx_reg]),
        .target (target_reg),
        .used   (used_reg),
        .found  (fm_found),
        .onehot (fm_onehot)
    );

    assign game_over = win_reg || (attempt_reg == ATTEMPT_MAX);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (!new_game && start && !game_over) state_next = ST_GREEN;
            ST_GREEN:  state_next = ST_YELLOW;
            ST_YELLOW: if (idx_reg == LAST_IDX) state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg   <= ST_IDLE;
            guess_reg   <= '0;
            target_reg  <= '0;
            used_reg    <= '0;
            idx_reg     <= '0;
            attempt_reg <= '0;
            win_reg     <= 1'b0;
            for (int i = 0; i < WORD_LEN; i++) result_reg[i] <= GRAY;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (new_game) begin
                        attempt_reg <= '0;
                        win_reg     <= 1'b0;
                    end else if (state_next == ST_GREEN) begin
                        guess_reg  <= guess;
                        target_reg <= target;
                    end
                end
                ST_GREEN: begin
                    for (int i = 0; i < WORD_LEN; i++)
                        result_reg[i] <= green_hit[i] ? GREEN : GRAY;
                    used_reg <= green_hit;
                    idx_reg  <= '0;
                end
                ST_YELLOW: begin
                    if (result_reg[idx_reg] != GREEN && fm_found) begin
                        result_reg[idx_reg] <= YELLOW;
                        used_reg            <= used_reg | fm_onehot;
                    end
                    idx_reg <= idx_reg + 3'd1;
                end
                ST_DONE: begin
                    if (attempt_reg != ATTEMPT_MAX) attempt_reg <= attempt_reg + 3'd1;
                    if (result_packed == {WORD_LEN{GREEN}}) win_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state_reg != ST_IDLE);
    assign done    = (state_reg == ST_DONE);
    assign result  = result_packed;
    assign attempt = attempt_reg;
    assign win     = win_reg;

endmodule

// File: tb/tb_wordle_guess_eval.sv
// Scoreboard bench for wordle_guess_eval: stimulus pushes expected gradings,
// a negedge monitor pops and checks them together with done latency.
module tb_wordle_guess_eval;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        new_game = 1'b0;
    logic        start = 1'b0;
    logic [24:0] guess = '0;
    logic [24:0] target = '0;
    logic        busy, done, win, game_over;
    logic [9:0]  result;
    logic [2:0]  attempt;

    typedef struct {
        logic [9:0] res;
        int         k;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic busy_seen;
    logic [24:0] g, t;

    wordle_guess_eval #(.MAX_GUESSES(6)) dut (
        .clk       (clk),
        .clr       (clr),
        .new_game  (new_game),
        .start     (start),
        .guess     (guess),
        .target    (target),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .attempt   (attempt),
        .win       (win),
        .game_over (game_over)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [24:0] w(input string s);
        logic [24:0] r;
        r = '0;
        for (int i = 0; i < 5; i++) r[5*i +: 5] = 5'(s[i] - 8'd65);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // cyc holds the index of the last rising edge; done must be seen 6 edges
    // after the edge that sampled start.
    always @(negedge clk) begin
        if (done) begin
            if (q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                $display("txn k=%0d result=%b attempt_before=%0d", e.k, result, attempt);
                check("result", 32'(result), 32'(e.res));
                check("done_latency", 32'(cyc - e.k), 32'd6);
            end
        end
    end

    task automatic issue(input logic [24:0] gw, input logic [24:0] tw, input logic [9:0] res);
        exp_t e;
        @(posedge clk) #1;
        start  = 1'b1;
        guess  = gw;
        target = tw;
        e.res  = res;
        e.k    = cyc + 1;
        q.push_back(e);
        @(posedge clk) #1;
        start = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && q.size() != 0; n++) @(posedge clk);
        if (q.size() != 0) begin
            check("done_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
        #1;
    endtask

    task automatic watch_busy(input string name);
        busy_seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            busy_seen = busy_seen | busy;
        end
        check(name, 32'(busy_seen), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_attempt", 32'(attempt), 32'd0);
        check("rst_win_over", 32'({win, game_over}), 32'd0);
        clr = 1'b0;

        issue(w("CRANE"), w("CRANE"), 10'b10_10_10_10_10);
        drain();
        check("crane_win", 32'(win), 32'd1);
        check("crane_over", 32'(game_over), 32'd1);
        check("crane_attempt", 32'(attempt), 32'd1);

        @(posedge clk) #1 new_game = 1'b1;
        @(posedge clk) #1 new_game = 1'b0;
        check("newgame_attempt", 32'(attempt), 32'd0);
        check("newgame_win_over", 32'({win, game_over}), 32'd0);

        issue(w("SPEED"), w("ABIDE"), 10'b01_00_01_00_00);
        drain();
        check("speed_win", 32'(win), 32'd0);
        check("speed_attempt", 32'(attempt), 32'd1);

        issue(w("EERIE"), w("THERE"), 10'b10_00_01_00_01);
        drain();
        check("eerie_attempt", 32'(attempt), 32'd2);

        // Second start at k+3 with another word must be ignored.
        issue(w("ABCDE"), w("EDCBA"), 10'b01_01_10_01_01);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; guess = w("CRANE"); target = w("CRANE");
        @(posedge clk) #1 start = 1'b0;
        drain();
        check("retrig_attempt", 32'(attempt), 32'd3);

        g = w("ZABCD"); g[4:0] = 5'd31;
        t = w("ZABCX"); t[4:0] = 5'd31;
        issue(g, t, 10'b00_10_10_10_00);
        drain();

        issue(w("HELLO"), w("WORLD"), 10'b01_10_00_00_00);
        drain();
        check("hello_over", 32'(game_over), 32'd0);
        issue(w("LLAMA"), w("ALPHA"), 10'b10_00_01_10_00);
        drain();
        check("six_attempt", 32'(attempt), 32'd6);
        check("six_over", 32'(game_over), 32'd1);
        check("six_win", 32'(win), 32'd0);

        @(posedge clk) #1;
        start = 1'b1; guess = w("CRANE"); target = w("CRANE");
        @(posedge clk) #1 start = 1'b0;
        watch_busy("over_start_ignored");
        check("over_attempt_held", 32'(attempt), 32'd6);

        @(posedge clk) #1 begin new_game = 1'b1; start = 1'b1; end
        @(posedge clk) #1 begin new_game = 1'b0; start = 1'b0; end
        check("ng_attempt", 32'(attempt), 32'd0);
        check("ng_over", 32'(game_over), 32'd0);
        watch_busy("ng_beats_start");

        issue(w("SPEED"), w("ABIDE"), 10'b01_00_01_00_00);
        drain();
        check("pre_clr_attempt", 32'(attempt), 32'd1);

        // Abort a guess in the middle of the yellow pass.
        @(posedge clk) #1;
        start = 1'b1; guess = w("EERIE"); target = w("THERE");
        @(posedge clk) #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("busy_before_clr", 32'(busy), 32'd1);
        clr = 1'b1;
        #1;
        check("clr_busy_done", 32'({busy, done}), 32'd0);
        check("clr_result", 32'(result), 32'd0);
        check("clr_attempt", 32'(attempt), 32'd0);
        check("clr_win_over", 32'({win, game_over}), 32'd0);
        repeat (2) @(posedge clk);
        #1 clr = 1'b0;
        repeat (10) @(posedge clk);

        issue(w("EERIE"), w("THERE"), 10'b10_00_01_00_01);
        drain();
        check("post_clr_attempt", 32'(attempt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
